// File: rtl/rtl_settings_pkg.sv
// Shared settings for the transmitter slice.
//   state_t    : command FSM encoding (IDLE_S, CREDIT_S, REQ_S)
//   ADDR_W     : default Avalon word address width
//   DATA_W     : default Avalon data width (multiple of 8)
//   TRANS_WR/TRANS_RD : values of the command type bit
package rtl_settings_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;

  localparam logic TRANS_WR = 1'b0;
  localparam logic TRANS_RD = 1'b1;

  typedef enum logic [1:0] {
    IDLE_S   = 2'd0,
    CREDIT_S = 2'd1,
    REQ_S    = 2'd2
  } state_t;

endpackage

// File: rtl/transmitter_block_if.sv
// Single-word Avalon-MM bus bundle between the transmitter (master) and memory (slave).
//   address/read/write/writedata/byteenable : master -> slave request
//   waitrequest                             : slave stall, request holds while high
//   readdata/readdatavalid                  : slave -> master read return
// Handshake: a request is taken by the slave on a clock edge where read or write is
// high and waitrequest is low; address, data and the request stay stable until then.
interface transmitter_block_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);

  logic [ADDR_W-1:0]   address;
  logic                read;
  logic                write;
  logic [DATA_W-1:0]   writedata;
  logic [DATA_W/8-1:0] byteenable;
  logic                waitrequest;
  logic [DATA_W-1:0]   readdata;
  logic                readdatavalid;

  modport master (
    output address, read, write, writedata, byteenable,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, read, write, writedata, byteenable,
    output waitrequest, readdata, readdatavalid
  );

endinterface

// File: rtl/transmitter_block.sv
// Memory-side end of the control->transmitter command interface.
// Accepts one command per trans_valid_i && !trans_process_o and drives a single-word
// Avalon-MM master, tracks outstanding reads and forwards read data.
// Ports:
//   clk_i, rst_i (async, active-high)
//   test_start_i, data_pattern_i      : write pattern byte load
//   trans_valid_i/type_i/addr_i       : command in; trans_process_o = slot occupied
//   trans_busy_o                      : command in flight or reads outstanding
//   amm_*                             : Avalon-MM master
//   rd_valid_o, rd_data_o             : registered read return to the compare block
//   trans_timeout_o                   : read-timeout pulse
// Build option: define TRANS_RD_TIMEOUT_EN to enable the outstanding-read timeout;
// otherwise trans_timeout_o is tied 0 and no timer exists.
module transmitter_block #(
  parameter int ADDR_W      = rtl_settings_pkg::ADDR_W,
  parameter int DATA_W      = rtl_settings_pkg::DATA_W,
  parameter int MAX_PENDING = 8,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                test_start_i,
  input  logic [7:0]          data_pattern_i,
  input  logic                trans_valid_i,
  input  logic                trans_type_i,
  input  logic [ADDR_W-1:0]   trans_addr_i,
  output logic                trans_process_o,
  output logic                trans_busy_o,
  output logic [ADDR_W-1:0]   amm_address_o,
  output logic                amm_read_o,
  output logic                amm_write_o,
  output logic [DATA_W-1:0]   amm_writedata_o,
  output logic [DATA_W/8-1:0] amm_byteenable_o,
  input  logic                amm_waitrequest_i,
  input  logic [DATA_W-1:0]   amm_readdata_i,
  input  logic                amm_readdatavalid_i,
  output logic                rd_valid_o,
  output logic [DATA_W-1:0]   rd_data_o,
  output logic                trans_timeout_o
);

  import rtl_settings_pkg::*;

  localparam int PEND_W = $clog2(MAX_PENDING + 1);
  localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_PENDING);

  state_t              state_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                type_q;
  logic [7:0]          pattern_q;
  logic [PEND_W-1:0]   pending_q;
  logic [PEND_W-1:0]   pending_d;
  logic                rd_valid_q;
  logic [DATA_W-1:0]   rd_data_q;

  logic accept;
  logic bus_rd_done;
  logic pend_dec;
  logic timeout_hit;

  assign accept      = trans_valid_i && (state_q == IDLE_S);
  assign bus_rd_done = (state_q == REQ_S) && (type_q == TRANS_RD) && !amm_waitrequest_i;
  // Data arriving with nothing outstanding (late or stray) is never counted.
  assign pend_dec    = amm_readdatavalid_i && (pending_q != '0);

  // Command FSM: addr/type latched on the accepting edge and held through REQ_S,
  // which keeps the Avalon request stable while waitrequest is high.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE_S;
      addr_q  <= '0;
      type_q  <= TRANS_WR;
    end else begin
      case (state_q)
        IDLE_S: begin
          if (accept) begin
            addr_q <= trans_addr_i;
            type_q <= trans_type_i;
            if ((trans_type_i == TRANS_RD) && (pending_q == PEND_MAX)) begin
              state_q <= CREDIT_S;
            end else begin
              state_q <= REQ_S;
            end
          end
        end
        CREDIT_S: begin
          if (pending_q < PEND_MAX) begin
            state_q <= REQ_S;
          end
        end
        REQ_S: begin
          if (!amm_waitrequest_i) begin
            state_q <= IDLE_S;
          end
        end
        default: state_q <= IDLE_S;
      endcase
    end
  end

  // Pattern byte reloads on any test start, independent of the FSM.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pattern_q <= '0;
    end else if (test_start_i) begin
      pattern_q <= data_pattern_i;
    end
  end

  // Outstanding read count; simultaneous issue and return cancel out.
  always_comb begin
    pending_d = pending_q;
    case ({bus_rd_done, pend_dec})
      2'b10:   pending_d = pending_q + 1'b1;
      2'b01:   pending_d = pending_q - 1'b1;
      default: pending_d = pending_q;
    endcase
    if (timeout_hit) begin
      pending_d = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  // Read return is forwarded unconditionally, one cycle late.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= amm_readdatavalid_i;
      rd_data_q  <= amm_readdata_i;
    end
  end

`ifdef TRANS_RD_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

  logic [TMR_W-1:0] timer_q;
  logic             timeout_q;

  // Fires on the edge where the timer would reach TIMEOUT_CYC.
  assign timeout_hit = (pending_q != '0) && !amm_readdatavalid_i && (timer_q == TMR_LAST);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      timer_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= timeout_hit;
      if ((pending_q == '0) || amm_readdatavalid_i || timeout_hit) begin
        timer_q <= '0;
      end else begin
        timer_q <= timer_q + 1'b1;
      end
    end
  end

  assign trans_timeout_o = timeout_q;
`else
  assign timeout_hit     = 1'b0;
  assign trans_timeout_o = 1'b0;
`endif

  assign trans_process_o  = (state_q != IDLE_S);
  assign trans_busy_o     = (state_q != IDLE_S) || (pending_q != '0);
  assign amm_address_o    = addr_q;
  assign amm_read_o       = (state_q == REQ_S) && (type_q == TRANS_RD);
  assign amm_write_o      = (state_q == REQ_S) && (type_q == TRANS_WR);
  assign amm_writedata_o  = {(DATA_W/8){pattern_q}};
  assign amm_byteenable_o = '1;
  assign rd_valid_o       = rd_valid_q;
  assign rd_data_o        = rd_data_q;

endmodule

// File: tb/tb_transmitter_block.sv
// Directed bench for transmitter_block: write, stalled read, credit stall at
// MAX_PENDING, simultaneous issue/return, stray read data, async reset in REQ_S,
// and the optional read timeout (TIMEOUT_CYC=16).
module tb_transmitter_block;

  localparam int AW = 16;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          test_start = 1'b0;
  logic [7:0]    data_pattern = '0;
  logic          trans_valid = 1'b0;
  logic          trans_type = 1'b0;
  logic [AW-1:0] trans_addr = '0;
  logic          trans_process;
  logic          trans_busy;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          trans_timeout;

  int checks = 0;
  int failures = 0;

  transmitter_block_if #(.ADDR_W(AW), .DATA_W(DW)) amm ();

  transmitter_block #(
    .ADDR_W(AW), .DATA_W(DW), .MAX_PENDING(8), .TIMEOUT_CYC(16)
  ) dut (
    .clk_i               (clk),
    .rst_i               (rst),
    .test_start_i        (test_start),
    .data_pattern_i      (data_pattern),
    .trans_valid_i       (trans_valid),
    .trans_type_i        (trans_type),
    .trans_addr_i        (trans_addr),
    .trans_process_o     (trans_process),
    .trans_busy_o        (trans_busy),
    .amm_address_o       (amm.address),
    .amm_read_o          (amm.read),
    .amm_write_o         (amm.write),
    .amm_writedata_o     (amm.writedata),
    .amm_byteenable_o    (amm.byteenable),
    .amm_waitrequest_i   (amm.waitrequest),
    .amm_readdata_i      (amm.readdata),
    .amm_readdatavalid_i (amm.readdatavalid),
    .rd_valid_o          (rd_valid),
    .rd_data_o           (rd_data),
    .trans_timeout_o     (trans_timeout)
  );

  // clock
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Holds trans_valid until an edge on which the slot is free; returns just after that edge.
  task automatic send_cmd(input logic typ, input logic [AW-1:0] addr);
    logic accepted;
    accepted = 1'b0;
    trans_valid = 1'b1;
    trans_type  = typ;
    trans_addr  = addr;
    for (int k = 0; k < 50; k++) begin
      if (!trans_process) begin
        tick();
        accepted = 1'b1;
        break;
      end
      tick();
    end
    trans_valid = 1'b0;
    check("cmd_accept", accepted, 1'b1);
  endtask

  task automatic rdv_pulse(input logic [DW-1:0] data);
    amm.readdatavalid = 1'b1;
    amm.readdata      = data;
    tick();
    amm.readdatavalid = 1'b0;
  endtask

  initial begin
    logic seen;
    amm.waitrequest   = 1'b0;
    amm.readdata      = '0;
    amm.readdatavalid = 1'b0;

    // reset state
    tick();
    tick();
    check("rst_process", trans_process, 1'b0);
    check("rst_busy", trans_busy, 1'b0);
    check("rst_read", amm.read, 1'b0);
    check("rst_write", amm.write, 1'b0);
    check("rst_addr", amm.address, 16'h0);
    check("rst_rd_valid", rd_valid, 1'b0);
    check("rst_rd_data", rd_data, 32'h0);
    check("rst_timeout", trans_timeout, 1'b0);
    rst = 1'b0;
    tick();

    // 1: write 0x10 with pattern 0xA5, no stall
    test_start = 1'b1;
    data_pattern = 8'hA5;
    tick();
    test_start = 1'b0;
    data_pattern = 8'h00;
    check("t1_wdata", amm.writedata, 32'hA5A5A5A5);
    send_cmd(1'b0, 16'h0010);
    check("t1_write", amm.write, 1'b1);
    check("t1_read", amm.read, 1'b0);
    check("t1_addr", amm.address, 16'h0010);
    check("t1_byteen", amm.byteenable, 4'hF);
    check("t1_process", trans_process, 1'b1);
    tick();
    check("t1_write_end", amm.write, 1'b0);
    check("t1_process_end", trans_process, 1'b0);
    check("t1_busy_end", trans_busy, 1'b0);

    // 2: read 0x20, waitrequest high 3 cycles, data two cycles after acceptance
    amm.waitrequest = 1'b1;
    send_cmd(1'b1, 16'h0020);
    check("t2_read_c1", amm.read, 1'b1);
    check("t2_addr", amm.address, 16'h0020);
    tick();
    check("t2_read_c2", amm.read, 1'b1);
    tick();
    check("t2_read_c3", amm.read, 1'b1);
    tick();
    amm.waitrequest = 1'b0;
    check("t2_read_c4", amm.read, 1'b1);
    tick();
    check("t2_read_end", amm.read, 1'b0);
    check("t2_busy_pending", trans_busy, 1'b1);
    tick();
    amm.readdatavalid = 1'b1;
    amm.readdata = 32'h0000_1234;
    check("t2_rdv_not_yet", rd_valid, 1'b0);
    tick();
    amm.readdatavalid = 1'b0;
    check("t2_rd_valid", rd_valid, 1'b1);
    check("t2_rd_data", rd_data, 32'h0000_1234);
    check("t2_busy_drained", trans_busy, 1'b0);

    // 3: nine back-to-back reads with no data; ninth waits for a credit
    for (int i = 0; i < 9; i++) begin
      send_cmd(1'b1, AW'(i));
    end
    check("t3_credit_process", trans_process, 1'b1);
    check("t3_credit_read", amm.read, 1'b0);
    tick();
    check("t3_credit_hold", amm.read, 1'b0);
    rdv_pulse(32'h0000_BEEF);
    seen = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (amm.read) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    check("t3_ninth_issue", seen, 1'b1);
    check("t3_ninth_addr", amm.address, 16'h0008);
    tick();
    for (int i = 0; i < 7; i++) begin
      rdv_pulse(DW'(i + 32'h100));
    end
    check("t3_busy_one_left", trans_busy, 1'b1);
    rdv_pulse(32'hCAFE_0001);
    check("t3_busy_drained", trans_busy, 1'b0);
    check("t3_last_data", rd_data, 32'hCAFE_0001);

    // 4: bus read acceptance and readdatavalid together at pending=3
    for (int i = 0; i < 3; i++) begin
      send_cmd(1'b1, AW'(16'h30 + i));
      tick();
    end
    send_cmd(1'b1, 16'h0040);
    rdv_pulse(32'h0000_0004);
    check("t4_busy_after_overlap", trans_busy, 1'b1);
    rdv_pulse(32'h0000_0005);
    rdv_pulse(32'h0000_0006);
    check("t4_busy_pending1", trans_busy, 1'b1);
    rdv_pulse(32'h0000_0007);
    check("t4_busy_drained", trans_busy, 1'b0);

    // stray read data at pending=0 must not underflow the counter
    rdv_pulse(32'hDEAD_BEEF);
    check("stray_rd_valid", rd_valid, 1'b1);
    check("stray_busy", trans_busy, 1'b0);
    tick();
    check("stray_busy_after", trans_busy, 1'b0);

    // 5: async reset during REQ_S with waitrequest high, one read outstanding
    send_cmd(1'b1, 16'h0060);
    tick();
    amm.waitrequest = 1'b1;
    send_cmd(1'b1, 16'h0061);
    check("t5_read_before", amm.read, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("t5_read_drop", amm.read, 1'b0);
    check("t5_write_drop", amm.write, 1'b0);
    check("t5_busy", trans_busy, 1'b0);
    check("t5_process", trans_process, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    amm.waitrequest = 1'b0;
    tick();
    check("t5_busy_after", trans_busy, 1'b0);

    // 6: one read with no data returned
    send_cmd(1'b1, 16'h0070);
    tick();
`ifdef TRANS_RD_TIMEOUT_EN
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (trans_timeout) seen = 1'b1;
    end
    check("t6_no_early_timeout", seen, 1'b0);
    check("t6_busy_waiting", trans_busy, 1'b1);
    tick();
    check("t6_timeout_pulse", trans_timeout, 1'b1);
    check("t6_busy_at_pulse", trans_busy, 1'b0);
    tick();
    check("t6_timeout_single", trans_timeout, 1'b0);
    check("t6_busy_after", trans_busy, 1'b0);
    rdv_pulse(32'h0000_1A7E);
    check("t6_late_forward", rd_valid, 1'b1);
    check("t6_late_busy", trans_busy, 1'b0);
`else
    repeat (20) tick();
    check("t6_no_timeout", trans_timeout, 1'b0);
    check("t6_busy_held", trans_busy, 1'b1);
    rdv_pulse(32'h0000_1A7E);
    check("t6_busy_drained", trans_busy, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
